// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with one-hot/binary grant and a hold-limit forced release.
// The release input is named release_i because "release" is a reserved word.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic [7:0] grant_o,
    output logic [2:0] grant_idx_o,
    output logic       grant_valid_o,
    output logic       timeout_o
);
    localparam int CW = $clog2(HOLD_MAX) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d, idx_q, idx_d, win;
    logic [7:0]      grant_q, grant_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d, end_c, done;

    // Walk offsets downward so the requester closest to ptr is the last to write win.
    always_comb begin
        win = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
        end
    end

    assign end_c = (HOLD_MAX > 0) && (hold_q == HOLD_LAST);
    assign done  = release_i || !req_i[idx_q] || end_c;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = BUSY;
                idx_d   = win;
                grant_d = 8'b1 << win;
                hold_d  = '0;
            end
        end else if (done) begin
            state_d   = IDLE;
            idx_d     = '0;
            grant_d   = '0;
            ptr_d     = idx_q + 3'd1;
            timeout_d = end_c && !release_i && req_i[idx_q];
        end else begin
            hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = (state_q == BUSY);
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors for rr_arbiter8 (HOLD_MAX=4) with hand-computed outputs.
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       rel = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid, timeout;
    int         n_vec = 0;
    int         n_err = 0;

    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_i(req), .release_i(rel),
        .grant_o(grant), .grant_idx_o(grant_idx),
        .grant_valid_o(grant_valid), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Packs {grant, idx, valid, timeout}; idle expectations pass v=0 and ignore idx.
    task automatic expect_out(input string tag, input logic v, input logic [2:0] idx, input logic t);
        logic [7:0] g;
        g = v ? 8'b1 << idx : 8'h00;
        chk(tag, {19'd0, grant, grant_idx, grant_valid, timeout}, {19'd0, g, v ? idx : 3'd0, v, t});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        // T1
        req = 8'h01;
        step(); expect_out("t1_grant0", 1'b1, 3'd0, 1'b0);
        rel = 1'b1;
        step(); expect_out("t1_release", 1'b0, 3'd0, 1'b0);
        rel = 1'b0;
        step(); expect_out("t1_regrant", 1'b1, 3'd0, 1'b0);
        // T2: release held high; IDLE ignores it, so owners alternate with one dead cycle
        req = 8'hFF;
        rel = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(); expect_out($sformatf("t2_idle%0d", i), 1'b0, 3'd0, 1'b0);
            step(); expect_out($sformatf("t2_own%0d", i), 1'b1, 3'(i % 8), 1'b0);
        end
        // T3: leave ptr at 5, then requesters 0 and 3 compete
        req = 8'h10;
        step(); expect_out("t3_idle_a", 1'b0, 3'd0, 1'b0);
        rel = 1'b0;
        step(); expect_out("t3_own4", 1'b1, 3'd4, 1'b0);
        rel = 1'b1;
        step(); expect_out("t3_idle_b", 1'b0, 3'd0, 1'b0);
        req = 8'h09;
        rel = 1'b0;
        step(); expect_out("t3_own0", 1'b1, 3'd0, 1'b0);
        rel = 1'b1;
        step(); expect_out("t3_end", 1'b0, 3'd0, 1'b0);
        rel = 1'b0;
        req = 8'h00;
        step(); expect_out("t3_noreq", 1'b0, 3'd0, 1'b0);
        // T4: ptr=1, hold limit expiry on requester 2
        req = 8'h24;
        for (int i = 0; i < 4; i++) begin
            step(); expect_out($sformatf("t4_hold%0d", i), 1'b1, 3'd2, 1'b0);
        end
        step(); expect_out("t4_timeout", 1'b0, 3'd0, 1'b1);
        step(); expect_out("t4_own5", 1'b1, 3'd5, 1'b0);
        // T5: release coincides with the limit cycle
        for (int i = 1; i < 4; i++) begin
            step(); expect_out($sformatf("t5_hold%0d", i), 1'b1, 3'd5, 1'b0);
        end
        rel = 1'b1;
        step(); expect_out("t5_rel_at_limit", 1'b0, 3'd0, 1'b0);
        rel = 1'b0;
        step(); expect_out("t5_own2", 1'b1, 3'd2, 1'b0);
        step(); expect_out("t5_own2_b", 1'b1, 3'd2, 1'b0);
        req = 8'h20;
        step(); expect_out("t5_drop", 1'b0, 3'd0, 1'b0);
        step(); expect_out("t5_own5", 1'b1, 3'd5, 1'b0);
        // T6: async reset mid-grant of requester 6
        rel = 1'b1;
        step(); expect_out("t6_idle", 1'b0, 3'd0, 1'b0);
        rel = 1'b0;
        req = 8'h40;
        step(); expect_out("t6_own6", 1'b1, 3'd6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("t6_async_clear", 1'b0, 3'd0, 1'b0);
        req = 8'hC1;
        step(); expect_out("t6_in_reset", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        step(); expect_out("t6_ptr_restart", 1'b1, 3'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
